// File: rtl/flit_depacketizer_if.sv
// flit_depacketizer_if -- flit ingress and word egress handshakes of flit_depacketizer.
//   flit_in/flit_valid/flit_ready : flit stream {type, cnt, lane[LANES-1]..lane[0]}
//   data_out/data_valid/data_ready: payload word stream
//   packet_end                    : marks the last word of a packet, qualified by data_valid
// Modports: slave = depacketizer side, master = producer/consumer side.
interface flit_depacketizer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 2
);
  localparam int unsigned CNT_W  = $clog2(LANES + 1);
  localparam int unsigned FLIT_W = 2 + CNT_W + LANES * DATA_W;

  logic [FLIT_W-1:0] flit_in;
  logic              flit_valid;
  logic              flit_ready;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              packet_end;

  modport slave (
    input  flit_in, flit_valid, data_ready,
    output flit_ready, data_out, data_valid, packet_end
  );

  modport master (
    output flit_in, flit_valid, data_ready,
    input  flit_ready, data_out, data_valid, packet_end
  );
endinterface

// File: rtl/flit_depacketizer.sv
// flit_depacketizer -- buffers head/body/tail flits in a small FIFO, strips the head,
// serialises payload lanes (lane 0 first) into DATA_W words and flags the last word.
// Malformed flit sequences raise err_proto instead of being sliced blindly.
// Ports:
//   clk, reset_n (async, active low)
//   bus       : flit_depacketizer_if.slave (flit input / word output handshakes)
//   err_proto : one-cycle pulse on a protocol error
//   err_len   : one-cycle pulse when a packet's word count differs from its head length
// Build option: define DEPKT_LEN_CHECK_EN to enable the length check; otherwise err_len is 0.
module flit_depacketizer #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LANES      = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  flit_depacketizer_if.slave   bus,
  output logic                 err_proto,
  output logic                 err_len
);
  localparam int unsigned CNT_W  = $clog2(LANES + 1);
  localparam int unsigned FLIT_W = 2 + CNT_W + LANES * DATA_W;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_HEAD, S_BODY, S_EMIT} state_t;
  typedef enum logic [1:0] {FT_BODY = 2'b00, FT_HEAD = 2'b01, FT_TAIL = 2'b10, FT_RSVD = 2'b11} ftype_t;

  // Flit FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              full, empty, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign bus.flit_ready = reset_n & ~full;
  assign push  = bus.flit_valid & bus.flit_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.flit_in;
  end

  logic [FLIT_W-1:0]             cur_flit;
  ftype_t                        cur_type;
  logic [CNT_W-1:0]              cur_cnt;
  logic [LANES-1:0][DATA_W-1:0]  cur_lanes;

  assign cur_flit  = mem_q[rd_ptr_q[AW-1:0]];
  assign cur_type  = ftype_t'(cur_flit[FLIT_W-1 -: 2]);
  assign cur_cnt   = cur_flit[FLIT_W-3 -: CNT_W];
  assign cur_lanes = cur_flit[LANES*DATA_W-1:0];

  state_t                       state_q, state_d;
  logic [LANES-1:0][DATA_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]             lane_idx_q, lane_idx_d;
  logic [CNT_W-1:0]             last_lane_q, last_lane_d;
  logic                         tail_q, tail_d;
  logic                         err_proto_q, err_proto_d;
`ifdef DEPKT_LEN_CHECK_EN
  logic [DATA_W-1:0]            len_q, len_d;
  logic [DATA_W-1:0]            wcnt_q, wcnt_d;
  logic                         err_len_q, err_len_d;
`endif

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    lane_idx_d  = lane_idx_q;
    last_lane_d = last_lane_q;
    tail_d      = tail_q;
    err_proto_d = 1'b0;
    pop         = 1'b0;
`ifdef DEPKT_LEN_CHECK_EN
    len_d       = len_q;
    wcnt_d      = wcnt_q;
    err_len_d   = 1'b0;
`endif
    case (state_q)
      S_HEAD: begin
        if (!empty) begin
          pop = 1'b1;
          if (cur_type == FT_HEAD) begin
            state_d = S_BODY;
`ifdef DEPKT_LEN_CHECK_EN
            len_d  = cur_lanes[0];
            wcnt_d = '0;
`endif
          end else begin
            err_proto_d = 1'b1;
          end
        end
      end
      S_BODY: begin
        if (!empty) begin
          pop = 1'b1;
          case (cur_type)
            FT_BODY: begin
              hold_d      = cur_lanes;
              lane_idx_d  = '0;
              last_lane_d = CNT_W'(LANES - 1);
              tail_d      = 1'b0;
              state_d     = S_EMIT;
            end
            FT_TAIL: begin
              if (cur_cnt != '0 && cur_cnt <= CNT_W'(LANES)) begin
                hold_d      = cur_lanes;
                lane_idx_d  = '0;
                last_lane_d = cur_cnt - CNT_W'(1);
                tail_d      = 1'b1;
                state_d     = S_EMIT;
              end else begin
                err_proto_d = 1'b1;
                state_d     = S_HEAD;
              end
            end
            FT_HEAD: begin
              // Unterminated packet is abandoned; this head opens the next one.
              err_proto_d = 1'b1;
`ifdef DEPKT_LEN_CHECK_EN
              len_d  = cur_lanes[0];
              wcnt_d = '0;
`endif
            end
            default: err_proto_d = 1'b1;
          endcase
        end
      end
      S_EMIT: begin
        if (bus.data_ready) begin
          lane_idx_d = lane_idx_q + CNT_W'(1);
`ifdef DEPKT_LEN_CHECK_EN
          wcnt_d = wcnt_q + DATA_W'(1);
`endif
          if (lane_idx_q == last_lane_q) begin
            state_d = tail_q ? S_HEAD : S_BODY;
`ifdef DEPKT_LEN_CHECK_EN
            if (tail_q && (wcnt_q + DATA_W'(1)) != len_q) err_len_d = 1'b1;
`endif
          end
        end
      end
      default: state_d = S_HEAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= S_HEAD;
      hold_q      <= '0;
      lane_idx_q  <= '0;
      last_lane_q <= '0;
      tail_q      <= 1'b0;
      err_proto_q <= 1'b0;
`ifdef DEPKT_LEN_CHECK_EN
      len_q       <= '0;
      wcnt_q      <= '0;
      err_len_q   <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      state_q     <= state_d;
      hold_q      <= hold_d;
      lane_idx_q  <= lane_idx_d;
      last_lane_q <= last_lane_d;
      tail_q      <= tail_d;
      err_proto_q <= err_proto_d;
`ifdef DEPKT_LEN_CHECK_EN
      len_q       <= len_d;
      wcnt_q      <= wcnt_d;
      err_len_q   <= err_len_d;
`endif
    end
  end

  always_comb begin
    bus.data_out = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_idx_q == CNT_W'(i)) bus.data_out = hold_q[i];
    end
  end

  assign bus.data_valid = (state_q == S_EMIT);
  assign bus.packet_end = (state_q == S_EMIT) && tail_q && (lane_idx_q == last_lane_q);
  assign err_proto      = err_proto_q;
`ifdef DEPKT_LEN_CHECK_EN
  assign err_len        = err_len_q;
`else
  assign err_len        = 1'b0;
`endif
endmodule

// File: tb/tb_flit_depacketizer.sv
// Testbench for flit_depacketizer at default parameters (DATA_W=16, LANES=2, FIFO_DEPTH=4).
module tb_flit_depacketizer;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned LANES      = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = $clog2(LANES + 1);
  localparam int unsigned FLIT_W     = 2 + CNT_W + LANES * DATA_W;
`ifdef DEPKT_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic err_proto, err_len;

  flit_depacketizer_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

  flit_depacketizer #(.DATA_W(DATA_W), .LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .err_proto (err_proto),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: packet-level view of the accepted flit stream.
  logic [DATA_W:0] exp_q[$];          // {last, word}
  bit              m_in_pkt = 1'b0;
  int unsigned     m_len = 0, m_words = 0;
  int unsigned     exp_proto = 0, exp_len = 0;

  task automatic model_flit(input logic [FLIT_W-1:0] f);
    logic [1:0]        t;
    logic [CNT_W-1:0]  cf;
    int unsigned       c;
    logic [DATA_W-1:0] w [LANES];
    t  = f[FLIT_W-1 -: 2];
    cf = f[FLIT_W-3 -: CNT_W];
    c  = int'(cf);
    for (int unsigned i = 0; i < LANES; i++) w[i] = f[i*DATA_W +: DATA_W];
    if (t == 2'b01) begin
      if (m_in_pkt) exp_proto++;
      m_in_pkt = 1'b1;
      m_len    = int'(w[0]);
      m_words  = 0;
    end else if (!m_in_pkt) begin
      exp_proto++;
    end else if (t == 2'b00) begin
      for (int unsigned i = 0; i < LANES; i++) exp_q.push_back({1'b0, w[i]});
      m_words += LANES;
    end else if (t == 2'b10 && c >= 1 && c <= LANES) begin
      for (int unsigned i = 0; i < c; i++) exp_q.push_back({(i == c - 1), w[i]});
      m_words += c;
      if (LEN_EN && (m_words % (1 << DATA_W)) != m_len) exp_len++;
      m_in_pkt = 1'b0;
    end else if (t == 2'b10) begin
      exp_proto++;
      m_in_pkt = 1'b0;
    end else begin
      exp_proto++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_in_pkt = 1'b0;
    m_words  = 0;
  endtask

  // Monitor: scoreboard, error pulse counts, output stability under backpressure.
  int unsigned       words_seen = 0, pend_seen = 0, proto_seen = 0, len_seen = 0;
  logic [DATA_W-1:0] last_word = '0;
  logic [DATA_W:0]   mon_e;
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] stall_data;
  logic              stall_pe;

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (err_proto) proto_seen++;
      if (err_len) len_seen++;
      if (stall_prev) begin
        check("hold_valid", bus.data_valid, 1);
        check("hold_data", bus.data_out, stall_data);
        check("hold_end", bus.packet_end, stall_pe);
      end
      if (bus.data_valid && bus.data_ready) begin
        words_seen++;
        last_word = bus.data_out;
        if (bus.packet_end) pend_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", bus.data_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", bus.data_out, mon_e[DATA_W-1:0]);
          check("word_end", bus.packet_end, mon_e[DATA_W]);
        end
      end
      stall_prev = bus.data_valid && !bus.data_ready;
      stall_data = bus.data_out;
      stall_pe   = bus.packet_end;
    end
  end

  bit rand_ready = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.data_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_flit(input logic [FLIT_W-1:0] f);
    int unsigned n;
    n = 0;
    bus.flit_in    = f;
    bus.flit_valid = 1'b1;
    while (!bus.flit_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.flit_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: flit_ready stayed 0, required 1 within 200 cycles");
      bus.flit_valid = 1'b0;
    end else begin
      tick();
      bus.flit_valid = 1'b0;
      model_flit(f);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [CNT_W-1:0] c,
                                           input logic [DATA_W-1:0] l1, input logic [DATA_W-1:0] l0);
    return {t, c, l1, l0};
  endfunction

  typedef struct {
    logic [1:0]        typ;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] l1, l0;
    int unsigned       nwords;
    logic [DATA_W-1:0] lastw;
    int unsigned       npend, nproto, nlen;
  } vec_t;

  vec_t              vecs[$];
  int unsigned       s_w, s_p, s_e, s_l;
  int unsigned       nb, tc, len;
  logic [63:0]       rnd;

  initial begin
    // typ cnt  lane1  lane0     words last  pend proto len
    vecs.push_back('{2'b01, 2'd0, 16'h0000, 16'd3,   0, 16'h0000, 0, 0, 0});
    vecs.push_back('{2'b00, 2'd0, 16'hBBBB, 16'hAAAA, 2, 16'hBBBB, 0, 0, 0});
    vecs.push_back('{2'b10, 2'd1, 16'h0000, 16'h1234, 1, 16'h1234, 1, 0, 0});
    vecs.push_back('{2'b00, 2'd0, 16'h1111, 16'h2222, 0, 16'h0000, 0, 1, 0});
    vecs.push_back('{2'b01, 2'd0, 16'h0000, 16'd2,   0, 16'h0000, 0, 0, 0});
    vecs.push_back('{2'b10, 2'd2, 16'h5555, 16'h4444, 2, 16'h5555, 1, 0, 0});
    vecs.push_back('{2'b01, 2'd0, 16'h0000, 16'd7,   0, 16'h0000, 0, 0, 0});
    vecs.push_back('{2'b00, 2'd0, 16'hC1C1, 16'hC0C0, 2, 16'hC1C1, 0, 0, 0});
    vecs.push_back('{2'b01, 2'd0, 16'h0000, 16'd2,   0, 16'h0000, 0, 1, 0});
    vecs.push_back('{2'b10, 2'd2, 16'hD1D1, 16'hD0D0, 2, 16'hD1D1, 1, 0, 0});
    vecs.push_back('{2'b01, 2'd0, 16'h0000, 16'd4,   0, 16'h0000, 0, 0, 0});
    vecs.push_back('{2'b00, 2'd0, 16'hE1E1, 16'hE0E0, 2, 16'hE1E1, 0, 0, 0});
    vecs.push_back('{2'b10, 2'd1, 16'h0000, 16'hF0F0, 1, 16'hF0F0, 1, 0, LEN_EN ? 1 : 0});
    vecs.push_back('{2'b01, 2'd0, 16'h0000, 16'd1,   0, 16'h0000, 0, 0, 0});
    vecs.push_back('{2'b10, 2'd0, 16'h0000, 16'h9999, 0, 16'h0000, 0, 1, 0});
    vecs.push_back('{2'b01, 2'd0, 16'h0000, 16'd1,   0, 16'h0000, 0, 0, 0});
    vecs.push_back('{2'b10, 2'd3, 16'h7777, 16'h8888, 0, 16'h0000, 0, 1, 0});
    vecs.push_back('{2'b11, 2'd0, 16'h0000, 16'h0001, 0, 16'h0000, 0, 1, 0});
    vecs.push_back('{2'b01, 2'd0, 16'h0000, 16'd2,   0, 16'h0000, 0, 0, 0});
    vecs.push_back('{2'b11, 2'd1, 16'h6666, 16'h6666, 0, 16'h0000, 0, 1, 0});
    vecs.push_back('{2'b10, 2'd2, 16'hA2A2, 16'hA1A1, 2, 16'hA2A2, 1, 0, 0});

    reset_n        = 1'b0;
    bus.flit_valid = 1'b0;
    bus.flit_in    = '0;
    bus.data_ready = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_flit_ready", bus.flit_ready, 0);
    check("rst_data_valid", bus.data_valid, 0);
    check("rst_packet_end", bus.packet_end, 0);
    check("rst_err_proto", err_proto, 0);
    check("rst_err_len", err_len, 0);
    check("rst_data_out", bus.data_out, 0);
    reset_n = 1'b1;
    tick();
    check("post_rst_flit_ready", bus.flit_ready, 1);
    check("post_rst_data_valid", bus.data_valid, 0);

    // Reset in the middle of a packet.
    send_flit(mk(2'b01, 2'd0, 16'h0000, 16'd2));
    send_flit(mk(2'b00, 2'd0, 16'h0A0B, 16'h0C0D));
    repeat (3) tick();
    check("mid_data_valid", bus.data_valid, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_data_valid", bus.data_valid, 0);
    check("mid_rst_packet_end", bus.packet_end, 0);
    check("mid_rst_err_proto", err_proto, 0);
    check("mid_rst_err_len", err_len, 0);
    check("mid_rst_data_out", bus.data_out, 0);
    check("mid_rst_flit_ready", bus.flit_ready, 0);
    tick();
    tick();
    model_reset();
    reset_n = 1'b1;
    tick();
    check("mid_post_flit_ready", bus.flit_ready, 1);
    check("mid_post_data_valid", bus.data_valid, 0);
    bus.data_ready = 1'b1;

    // Table-driven flit sequences.
    foreach (vecs[k]) begin
      s_w = words_seen; s_p = pend_seen; s_e = proto_seen; s_l = len_seen;
      send_flit(mk(vecs[k].typ, vecs[k].cnt, vecs[k].l1, vecs[k].l0));
      repeat (6) tick();
      check($sformatf("v%0d_words", k), words_seen - s_w, vecs[k].nwords);
      check($sformatf("v%0d_pend", k), pend_seen - s_p, vecs[k].npend);
      check($sformatf("v%0d_err_proto", k), proto_seen - s_e, vecs[k].nproto);
      check($sformatf("v%0d_err_len", k), len_seen - s_l, vecs[k].nlen);
      if (vecs[k].nwords > 0) check($sformatf("v%0d_last_word", k), last_word, vecs[k].lastw);
    end

    // Backpressure: FIFO fills while the output stalls.
    bus.data_ready = 1'b0;
    send_flit(mk(2'b01, 2'd0, 16'h0000, 16'd10));
    for (int i = 0; i < 4; i++)
      send_flit(mk(2'b00, 2'd0, 16'(16'h3100 + i), 16'(16'h3000 + i)));
    send_flit(mk(2'b10, 2'd2, 16'h3F01, 16'h3F00));
    check("bp_flit_ready", bus.flit_ready, 0);
    check("bp_data_valid", bus.data_valid, 1);
    check("bp_data_out", bus.data_out, 16'h3000);
    repeat (5) tick();
    check("bp_data_out_held", bus.data_out, 16'h3000);
    s_w = words_seen; s_p = pend_seen;
    bus.data_ready = 1'b1;
    repeat (30) tick();
    check("bp_words", words_seen - s_w, 10);
    check("bp_pend", pend_seen - s_p, 1);
    check("bp_queue_empty", exp_q.size(), 0);

    // Randomized packets with occasional junk flits and random backpressure.
    rand_ready = 1'b1;
    for (int p = 0; p < 80; p++) begin
      nb  = $urandom_range(0, 3);
      tc  = $urandom_range(1, LANES);
      len = nb * LANES + tc;
      if ($urandom_range(0, 4) == 0) len = len + 1;
      send_flit(mk(2'b01, 2'd0, 16'($urandom), 16'(len)));
      for (int b = 0; b < int'(nb); b++) begin
        send_flit(mk(2'b00, 2'($urandom), 16'($urandom), 16'($urandom)));
        if ($urandom_range(0, 9) == 0) begin
          rnd = {$urandom, $urandom};
          send_flit(rnd[FLIT_W-1:0]);
        end
      end
      send_flit(mk(2'b10, CNT_W'(tc), 16'($urandom), 16'($urandom)));
    end
    rand_ready = 1'b0;
    bus.data_ready = 1'b1;
    repeat (40) tick();

    check("final_queue_empty", exp_q.size(), 0);
    check("final_err_proto_total", proto_seen, exp_proto);
    check("final_err_len_total", len_seen, exp_len);
    check("final_data_valid", bus.data_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
